// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: round-robin coherence-bus arbiter with an urgent class and a grant held until xfer_done.
// Optional watchdog revoke of a stuck grant is built when BUS_ARB_WATCHDOG_EN is defined.
module bus_rr_arbiter #(
   parameter int NUM_CPUS = 4,
   parameter int IDW = $clog2(NUM_CPUS),
   parameter int TIMEOUT = 10000
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [NUM_CPUS-1:0] req_i,
   input  logic [NUM_CPUS-1:0] req_urgent_i,
   input  logic                snoop_stall_i,
   input  logic                xfer_done_i,
   output logic [NUM_CPUS-1:0] gnt_o,
   output logic [IDW-1:0]      gnt_id_o,
   output logic                gnt_valid_o,
   output logic                timeout_err_o
);
   typedef enum logic [1:0] {IDLE, OWNED, TURN} state_t;
   state_t state_q, state_d;
   logic [NUM_CPUS-1:0] gnt_q, gnt_d, cand;
   logic [IDW-1:0] id_q, id_d, ptr_q, ptr_d, win;
   logic found, expire, done;

   function automatic logic [IDW-1:0] wrap(input int k);
      return IDW'(k >= NUM_CPUS ? k - NUM_CPUS : k);
   endfunction

   // Urgent requests, when present, are the only candidates; scan starts at ptr.
   always_comb begin
      cand = |(req_i & req_urgent_i) ? (req_i & req_urgent_i) : req_i;
      win = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_CPUS; i++) begin
         if (!found && cand[wrap(int'(ptr_q) + i)]) begin
            win = wrap(int'(ptr_q) + i);
            found = 1'b1;
         end
      end
   end

   assign done = xfer_done_i | expire;

   always_comb begin
      state_d = state_q;
      gnt_d = gnt_q;
      id_d = id_q;
      ptr_d = ptr_q;
      if (state_q == IDLE && |req_i && !snoop_stall_i) begin
         state_d = OWNED;
         gnt_d = NUM_CPUS'(1) << win;
         id_d = win;
      end else if (state_q == OWNED && done) begin
         state_d = TURN;
         gnt_d = '0;
         ptr_d = wrap(int'(id_q) + 1);
      end else if (state_q == TURN) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         gnt_q <= '0;
         id_q <= '0;
         ptr_q <= '0;
      end else begin
         state_q <= state_d;
         gnt_q <= gnt_d;
         id_q <= id_d;
         ptr_q <= ptr_d;
      end
   end

`ifdef BUS_ARB_WATCHDOG_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt_q;
   logic err_q;
   // A completion arriving in the expiry cycle wins over the watchdog.
   assign expire = state_q == OWNED && cnt_q == CW'(TIMEOUT - 1) && !xfer_done_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= state_q == OWNED ? cnt_q + 1'b1 : '0;
         err_q <= err_q | expire;
      end
   end

   assign timeout_err_o = err_q;
`else
   assign expire = 1'b0;
   assign timeout_err_o = 1'b0;
`endif

   assign gnt_o = gnt_q;
   assign gnt_id_o = id_q;
   assign gnt_valid_o = |gnt_q;
endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb_bus_rr_arbiter: directed vector table, hand sequences and randomized run against a reference model.
module tb_bus_rr_arbiter;
   localparam int N = 4;
`ifdef BUS_ARB_WATCHDOG_EN
   localparam int TO = 8;
   localparam bit WD = 1'b1;
`else
   localparam int TO = 10000;
   localparam bit WD = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [N-1:0] req = '0, urg = '0;
   logic stall = 1'b0, xfer = 1'b0;
   logic [N-1:0] gnt;
   logic [1:0] gnt_id;
   logic gnt_valid, terr;

   int n_cmp = 0, n_bad = 0;

   always #5 clk = ~clk;

   bus_rr_arbiter #(.NUM_CPUS(N), .TIMEOUT(TO)) dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .req_urgent_i(urg),
      .snoop_stall_i(stall), .xfer_done_i(xfer),
      .gnt_o(gnt), .gnt_id_o(gnt_id), .gnt_valid_o(gnt_valid), .timeout_err_o(terr)
   );

   typedef struct {
      logic [N-1:0] req, urg;
      logic stall, xfer, rst;
      logic [N-1:0] e_gnt;
      logic e_valid;
      int e_id;
   } vec_t;
   vec_t tbl[$];

   function automatic void add(logic [N-1:0] r, logic [N-1:0] u, logic s, logic x, logic rs,
                               logic [N-1:0] eg, int eid);
      vec_t v;
      v.req = r; v.urg = u; v.stall = s; v.xfer = x; v.rst = rs;
      v.e_gnt = eg; v.e_valid = |eg; v.e_id = eid;
      tbl.push_back(v);
   endfunction

   task automatic chk(string name, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: owner index (-1 = none), a turnaround flag and a rotating start position.
   int m_owner = -1, m_id = 0, m_ptr = 0, m_cnt = 0;
   bit m_turn = 0, m_err = 0;

   function automatic int pick(logic [N-1:0] r, logic [N-1:0] u, int p);
      logic [N-1:0] c;
      c = |(r & u) ? (r & u) : r;
      for (int k = 0; k < N; k++) if (c[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   task automatic model_step();
      bit exp_now;
      if (rst) begin
         m_owner = -1; m_id = 0; m_ptr = 0; m_turn = 0; m_cnt = 0; m_err = 0;
      end else if (m_turn) begin
         m_turn = 0;
      end else if (m_owner >= 0) begin
         exp_now = WD && m_cnt == TO - 1 && !xfer;
         if (xfer || exp_now) begin
            m_err = m_err | exp_now;
            m_ptr = (m_id + 1) % N;
            m_owner = -1;
            m_turn = 1;
         end else m_cnt++;
      end else if (|req && !stall) begin
         m_owner = pick(req, urg, m_ptr);
         m_id = m_owner;
         m_cnt = 0;
      end
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk);
      #1;
      chk("gnt", int'(gnt), m_owner >= 0 ? (1 << m_owner) : 0);
      chk("gnt_valid", int'(gnt_valid), int'(m_owner >= 0));
      chk("gnt_id", int'(gnt_id), m_id);
      chk("timeout_err", int'(terr), int'(m_err));
   endtask

   initial begin
      int hi;
      // reset then idle with no requests
      add('0, '0, 0, 0, 1, '0, 0);
      for (int i = 0; i < 10; i++) add('0, '0, 0, 0, 0, '0, 0);
      // full rotation 0,1,2,3,0 with a two-cycle gap between grants
      for (int g = 0; g < 5; g++) begin
         for (int k = 0; k < 3; k++) add(4'b1111, '0, 0, 0, 0, 4'(1 << (g % 4)), g % 4);
         add(4'b1111, '0, 0, 1, 0, '0, g % 4);
         add(4'b1111, '0, 0, 0, 0, '0, g % 4);
      end
      // grant 1 so ptr lands on 2
      add(4'b0010, '0, 0, 0, 0, 4'b0010, 1);
      add(4'b0010, '0, 0, 1, 0, '0, 1);
      add('0, '0, 0, 0, 0, '0, 1);
      // urgent cache 0 wins over normal cache 1 despite ptr=2
      add(4'b0011, 4'b0001, 0, 0, 0, 4'b0001, 0);
      add(4'b0011, 4'b0001, 0, 1, 0, '0, 0);
      add(4'b0011, '0, 0, 0, 0, '0, 0);
      add(4'b0011, '0, 0, 0, 0, 4'b0010, 1);
      add(4'b0011, '0, 0, 1, 0, '0, 1);
      add('0, '0, 0, 0, 0, '0, 1);
      // snoop stall blocks new grants only
      for (int i = 0; i < 5; i++) add(4'b0100, '0, 1, 0, 0, '0, 1);
      add(4'b0100, '0, 0, 0, 0, 4'b0100, 2);
      add(4'b0100, '0, 1, 0, 0, 4'b0100, 2);
      add(4'b0000, 4'b1111, 1, 0, 0, 4'b0100, 2);
      add(4'b0000, '0, 1, 1, 0, '0, 2);
      add('0, '0, 0, 0, 0, '0, 2);
      // owner 3 drops req, reset releases the grant and ptr restarts at 0
      add(4'b1000, '0, 0, 0, 0, 4'b1000, 3);
      add('0, '0, 0, 0, 0, 4'b1000, 3);
      add('0, '0, 0, 1, 1, '0, 0);
      add(4'b1001, '0, 0, 0, 0, 4'b0001, 0);
      add(4'b1001, '0, 0, 1, 0, '0, 0);
      add('0, '0, 0, 0, 0, '0, 0);

      foreach (tbl[i]) begin
         req = tbl[i].req; urg = tbl[i].urg; stall = tbl[i].stall;
         xfer = tbl[i].xfer; rst = tbl[i].rst;
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d.gnt", i), int'(gnt), int'(tbl[i].e_gnt));
         chk($sformatf("vec%0d.valid", i), int'(gnt_valid), int'(tbl[i].e_valid));
         chk($sformatf("vec%0d.id", i), int'(gnt_id), tbl[i].e_id);
         chk($sformatf("vec%0d.terr", i), int'(terr), 0);
      end

`ifdef BUS_ARB_WATCHDOG_EN
      // no xfer_done: grant held exactly TO cycles, then revoked with a sticky error
      req = '0; urg = '0; stall = 0; xfer = 0; rst = 1;
      cyc();
      rst = 0; req = 4'b0001;
      cyc();
      req = '0;
      hi = 1;
      for (int i = 0; i < 20; i++) begin
         cyc();
         hi += int'(gnt_valid);
      end
      chk("wd_hold", hi, TO);
      chk("wd_err", int'(terr), 1);
      req = 4'b0010;
      cyc();
      req = '0;
      xfer = 1;
      cyc();
      xfer = 0;
      cyc();
      chk("wd_sticky", int'(terr), 1);
      // xfer_done coinciding with expiry is a normal completion
      rst = 1;
      cyc();
      rst = 0; req = 4'b0001;
      cyc();
      req = '0;
      for (int i = 0; i < TO - 1; i++) cyc();
      chk("wd_last_cycle_gnt", int'(gnt), 1);
      xfer = 1;
      cyc();
      xfer = 0;
      chk("wd_done_gnt", int'(gnt), 0);
      chk("wd_done_err", int'(terr), 0);
`endif

      // randomized run against the reference model
      req = '0; urg = '0; stall = 0; xfer = 0; rst = 1;
      cyc();
      rst = 0;
      for (int i = 0; i < 3000; i++) begin
         req = N'($urandom);
         urg = $urandom_range(0, 3) == 0 ? N'($urandom) : '0;
         stall = $urandom_range(0, 4) == 0;
         xfer = $urandom_range(0, 3) == 0;
         rst = $urandom_range(0, 199) == 0;
         cyc();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
